// File: rtl/sd_bitstream_decimator_if.sv
// Bitstream-in / decimated-sample-out bundle for sd_bitstream_decimator.
// The master side feeds the bitstreams; the slave side is the decimator.
`timescale 1ns/1ps
interface sd_bitstream_decimator_if #(
   parameter int unsigned OUT_BW = 16
);
   logic                     en;
   logic                     sin_bs;
   logic                     cos_bs;
   logic signed [OUT_BW-1:0] sin_out;
   logic signed [OUT_BW-1:0] cos_out;
   logic                     out_valid;

   modport master (
      output en, sin_bs, cos_bs,
      input  sin_out, cos_out, out_valid
   );

   modport slave (
      input  en, sin_bs, cos_bs,
      output sin_out, cos_out, out_valid
   );
endinterface

// File: rtl/sd_bitstream_decimator.sv
// Dual-channel sinc3 (third-order CIC) decimator for the sin/cos sigma-delta bitstreams.
// Both channels share one decimation counter, so output samples are always aligned.
`timescale 1ns/1ps
module sd_bitstream_decimator #(
   parameter int unsigned LOG2_DEC = 8,
   parameter int unsigned OUT_BW   = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   sd_bitstream_decimator_if.slave dec_io
);
   // Internal width: R^3 growth plus sign plus one bit so +R^3 is representable.
   localparam int unsigned W     = 3 * LOG2_DEC + 2;
   localparam int unsigned Shift = 3 * LOG2_DEC + 1 - OUT_BW;

   typedef logic signed [W-1:0] acc_t;

   localparam logic [LOG2_DEC-1:0] CntMax = '1;
   localparam acc_t SatHi = {{(W - OUT_BW + 1){1'b0}}, {(OUT_BW - 1){1'b1}}};
   localparam acc_t SatLo = {{(W - OUT_BW + 1){1'b1}}, {(OUT_BW - 1){1'b0}}};
   localparam acc_t PlusOne = acc_t'(1);

   // Channel 0 = sine, channel 1 = cosine.
   acc_t int1_q [2], int1_d [2];
   acc_t int2_q [2], int2_d [2];
   acc_t int3_q [2], int3_d [2];
   acc_t dly1_q [2], dly1_d [2];
   acc_t dly2_q [2], dly2_d [2];
   acc_t dly3_q [2], dly3_d [2];
   acc_t x_in   [2];
   acc_t comb1  [2];
   acc_t comb2  [2];
   acc_t comb3  [2];
   acc_t scaled [2];
   logic signed [OUT_BW-1:0] out_q [2], out_d [2];

   logic [LOG2_DEC-1:0] dec_cnt_q, dec_cnt_d;
   logic [1:0]          prime_cnt_q, prime_cnt_d;
   logic                out_valid_q, out_valid_d;
   logic                accept;
   logic                dec_event;

   assign accept    = dec_io.en;
   assign dec_event = accept && (dec_cnt_q == CntMax);

   // Integrator cascade, comb section, scaling/saturation and control next-state.
   always_comb begin
      x_in[0] = dec_io.sin_bs ? PlusOne : '1;
      x_in[1] = dec_io.cos_bs ? PlusOne : '1;

      for (int ch = 0; ch < 2; ch++) begin
         int1_d[ch] = int1_q[ch];
         int2_d[ch] = int2_q[ch];
         int3_d[ch] = int3_q[ch];
         dly1_d[ch] = dly1_q[ch];
         dly2_d[ch] = dly2_q[ch];
         dly3_d[ch] = dly3_q[ch];
         out_d[ch]  = out_q[ch];

         // Single-cycle cascade: each stage sees the updated value of the previous one.
         if (accept) begin
            int1_d[ch] = int1_q[ch] + x_in[ch];
            int2_d[ch] = int2_q[ch] + int1_d[ch];
            int3_d[ch] = int3_q[ch] + int2_d[ch];
         end

         comb1[ch]  = int3_d[ch] - dly1_q[ch];
         comb2[ch]  = comb1[ch] - dly2_q[ch];
         comb3[ch]  = comb2[ch] - dly3_q[ch];
         scaled[ch] = comb3[ch] >>> Shift;

         if (dec_event) begin
            dly1_d[ch] = int3_d[ch];
            dly2_d[ch] = comb1[ch];
            dly3_d[ch] = comb2[ch];
            // +R^3 lands one LSB above the positive limit; clamp it.
            if (scaled[ch] > SatHi) begin
               out_d[ch] = SatHi[OUT_BW-1:0];
            end else if (scaled[ch] < SatLo) begin
               out_d[ch] = SatLo[OUT_BW-1:0];
            end else begin
               out_d[ch] = scaled[ch][OUT_BW-1:0];
            end
         end
      end

      dec_cnt_d   = accept ? dec_cnt_q + 1'b1 : dec_cnt_q;
      prime_cnt_d = prime_cnt_q;
      if (dec_event && (prime_cnt_q != 2'd2)) begin
         prime_cnt_d = prime_cnt_q + 2'd1;
      end
      // First two frames only fill the comb delays; suppress their strobes.
      out_valid_d = dec_event && (prime_cnt_q == 2'd2);
   end

   // State and registered outputs; asynchronous reset clears everything, including priming.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int ch = 0; ch < 2; ch++) begin
            int1_q[ch] <= '0;
            int2_q[ch] <= '0;
            int3_q[ch] <= '0;
            dly1_q[ch] <= '0;
            dly2_q[ch] <= '0;
            dly3_q[ch] <= '0;
            out_q[ch]  <= '0;
         end
         dec_cnt_q   <= '0;
         prime_cnt_q <= '0;
         out_valid_q <= 1'b0;
      end else begin
         for (int ch = 0; ch < 2; ch++) begin
            int1_q[ch] <= int1_d[ch];
            int2_q[ch] <= int2_d[ch];
            int3_q[ch] <= int3_d[ch];
            dly1_q[ch] <= dly1_d[ch];
            dly2_q[ch] <= dly2_d[ch];
            dly3_q[ch] <= dly3_d[ch];
            out_q[ch]  <= out_d[ch];
         end
         dec_cnt_q   <= dec_cnt_d;
         prime_cnt_q <= prime_cnt_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign dec_io.sin_out   = out_q[0];
   assign dec_io.cos_out   = out_q[1];
   assign dec_io.out_valid = out_valid_q;

endmodule

// File: tb/tb_sd_bitstream_decimator.sv
// Bench for sd_bitstream_decimator: a default instance (R=256, 16-bit) and a small corner
// instance (R=4, 7-bit). Reference outputs come from a direct sinc3 FIR convolution over the
// accepted-sample history, not from an integrator/comb structure.
`timescale 1ns/1ps
module tb_sd_bitstream_decimator;
   localparam int L0  = 8;
   localparam int BW0 = 16;
   localparam int R0  = 1 << L0;
   localparam int L1  = 2;
   localparam int BW1 = 7;
   localparam int R1  = 1 << L1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sd_bitstream_decimator_if #(.OUT_BW(BW0)) if0 ();
   sd_bitstream_decimator_if #(.OUT_BW(BW1)) if1 ();

   sd_bitstream_decimator #(.LOG2_DEC(L0), .OUT_BW(BW0)) u_dut0 (
      .clk    (clk),
      .rst_n  (rst_n),
      .dec_io (if0)
   );

   sd_bitstream_decimator #(.LOG2_DEC(L1), .OUT_BW(BW1)) u_dut1 (
      .clk    (clk),
      .rst_n  (rst_n),
      .dec_io (if1)
   );

   typedef struct {
      logic [3:0] sin_pat;   // bit k = bitstream value of accepted sample k (mod 4)
      logic [3:0] cos_pat;
      int         en_period; // en high once every en_period cycles
      int         first_cyc; // cycle of first strobe, first accepted cycle counted as 1
      int         spacing;
      int         exp_sin;
      int         exp_cos;
   } row_t;

   row_t rows [4];

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model state.
   int h0 [$];
   int h1 [$];
   int qs0 [$], qc0 [$], qs1 [$], qc1 [$];
   int smp_cnt  [2];
   int ev_cnt   [2];
   int exp_sin  [2];
   int exp_cos  [2];
   bit exp_valid[2];

   task automatic cmp(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Number of (a,b,c) in [0,r)^3 with a+b+c = k: the sinc3 impulse response.
   function automatic int hcoef(input int r, input int k);
      int cnt = 0;
      for (int a = 0; a < r; a++) begin
         int lo = k - a - (r - 1);
         int hi = k - a;
         if (lo < 0) lo = 0;
         if (hi > r - 1) hi = r - 1;
         if (hi >= lo) cnt += hi - lo + 1;
      end
      return cnt;
   endfunction

   function automatic int fir(input int q[$], input int h[$], input int l2, input int bw);
      longint acc = 0;
      longint hi_lim = (64'sd1 <<< (bw - 1)) - 1;
      longint lo_lim = -(64'sd1 <<< (bw - 1));
      int n = q.size();
      for (int k = 0; k < h.size() && k < n; k++) begin
         acc += longint'(h[k]) * longint'(q[n - 1 - k]);
      end
      acc = acc >>> (3 * l2 + 1 - bw);
      if (acc > hi_lim) acc = hi_lim;
      if (acc < lo_lim) acc = lo_lim;
      return int'(acc);
   endfunction

   task automatic model_clear();
      qs0.delete(); qc0.delete(); qs1.delete(); qc1.delete();
      for (int i = 0; i < 2; i++) begin
         smp_cnt[i] = 0; ev_cnt[i] = 0;
         exp_sin[i] = 0; exp_cos[i] = 0; exp_valid[i] = 1'b0;
      end
   endtask

   task automatic model_update(input int sel, input bit e, input bit s, input bit c);
      exp_valid[sel] = 1'b0;
      if (!e) return;
      smp_cnt[sel]++;
      if (sel == 0) begin
         qs0.push_back(s ? 1 : -1);
         qc0.push_back(c ? 1 : -1);
         if (qs0.size() > h0.size()) begin
            void'(qs0.pop_front());
            void'(qc0.pop_front());
         end
         if (smp_cnt[0] % R0 == 0) begin
            ev_cnt[0]++;
            exp_sin[0]   = fir(qs0, h0, L0, BW0);
            exp_cos[0]   = fir(qc0, h0, L0, BW0);
            exp_valid[0] = (ev_cnt[0] >= 3);
         end
      end else begin
         qs1.push_back(s ? 1 : -1);
         qc1.push_back(c ? 1 : -1);
         if (qs1.size() > h1.size()) begin
            void'(qs1.pop_front());
            void'(qc1.pop_front());
         end
         if (smp_cnt[1] % R1 == 0) begin
            ev_cnt[1]++;
            exp_sin[1]   = fir(qs1, h1, L1, BW1);
            exp_cos[1]   = fir(qc1, h1, L1, BW1);
            exp_valid[1] = (ev_cnt[1] >= 3);
         end
      end
   endtask

   // One clock: capture driven inputs, advance, update model, check both instances.
   task automatic step();
      bit e0 = if0.en, s0 = if0.sin_bs, c0 = if0.cos_bs;
      bit e1 = if1.en, s1 = if1.sin_bs, c1 = if1.cos_bs;
      @(posedge clk);
      #1;
      if (rst_n) begin
         model_update(0, e0, s0, c0);
         model_update(1, e1, s1, c1);
      end
      cmp("dut0_valid", int'(if0.out_valid), int'(exp_valid[0]));
      cmp("dut0_sin",   int'(if0.sin_out),   exp_sin[0]);
      cmp("dut0_cos",   int'(if0.cos_out),   exp_cos[0]);
      cmp("dut1_valid", int'(if1.out_valid), int'(exp_valid[1]));
      cmp("dut1_sin",   int'(if1.sin_out),   exp_sin[1]);
      cmp("dut1_cos",   int'(if1.cos_out),   exp_cos[1]);
   endtask

   task automatic idle_inputs();
      if0.en = 1'b0; if0.sin_bs = 1'b0; if0.cos_bs = 1'b0;
      if1.en = 1'b0; if1.sin_bs = 1'b0; if1.cos_bs = 1'b0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      rst_n = 1'b0;
      model_clear();
      repeat (5) step();
      rst_n = 1'b1;
   endtask

   task automatic run_row(input int idx, input bit do_reset);
      row_t rw = rows[idx];
      int cur = 1, acc = 0, nstr = 0, last = 0;
      bit prev_en;
      if (do_reset) apply_reset();
      while (nstr < 5 && cur < rw.first_cyc + 5 * rw.spacing + 8) begin
         if0.en     = ((cur - 1) % rw.en_period == 0);
         if0.sin_bs = rw.sin_pat[acc % 4];
         if0.cos_bs = rw.cos_pat[acc % 4];
         if (if0.en) acc++;
         prev_en = if0.en;
         step();
         cur++;
         if (!prev_en) cmp($sformatf("row%0d_valid_after_gap", idx), int'(if0.out_valid), 0);
         if (if0.out_valid) begin
            if (nstr == 0) cmp($sformatf("row%0d_first_strobe_cycle", idx), cur, rw.first_cyc);
            else           cmp($sformatf("row%0d_strobe_spacing", idx), cur - last, rw.spacing);
            cmp($sformatf("row%0d_sin", idx), int'(if0.sin_out), rw.exp_sin);
            cmp($sformatf("row%0d_cos", idx), int'(if0.cos_out), rw.exp_cos);
            last = cur;
            nstr++;
         end
      end
      cmp($sformatf("row%0d_strobe_count", idx), nstr, 5);
      if0.en = 1'b0;
   endtask

   initial begin
      int cur, nstr, last;

      rows[0] = '{4'b1111, 4'b0000, 1, 3 * R0 + 1,     R0,     32767, -32768};
      rows[1] = '{4'b0101, 4'b0101, 1, 3 * R0 + 1,     R0,     0,      0};
      rows[2] = '{4'b1111, 4'b0000, 3, 9 * R0 - 1,     3 * R0, 32767, -32768};
      rows[3] = '{4'b0111, 4'b1000, 1, 3 * R0 + 1,     R0,     16384, -16384};

      for (int k = 0; k <= 3 * R0 - 3; k++) h0.push_back(hcoef(R0, k));
      for (int k = 0; k <= 3 * R1 - 3; k++) h1.push_back(hcoef(R1, k));

      idle_inputs();
      model_clear();

      // Table-driven scenarios on the default instance.
      for (int i = 0; i < 4; i++) run_row(i, 1'b1);

      // Reset asserted during the second frame of the priming run.
      apply_reset();
      for (int i = 0; i < R0 + R0 / 2; i++) begin
         if0.en = 1'b1; if0.sin_bs = 1'b1; if0.cos_bs = 1'b0;
         step();
      end
      cmp("pre_reset_sin_nonzero", int'(if0.sin_out != 0), 1);
      #1;
      rst_n = 1'b0;
      model_clear();
      #1;
      cmp("async_reset_sin",   int'(if0.sin_out),   0);
      cmp("async_reset_cos",   int'(if0.cos_out),   0);
      cmp("async_reset_valid", int'(if0.out_valid), 0);
      if0.en = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      run_row(0, 1'b0);

      // Randomized traffic on both instances, checked by the FIR model every cycle.
      apply_reset();
      for (int i = 0; i < 12 * R0; i++) begin
         if0.en     = ($urandom_range(0, 3) != 0);
         if0.sin_bs = 1'($urandom_range(0, 1));
         if0.cos_bs = 1'($urandom_range(0, 1));
         if1.en     = ($urandom_range(0, 3) != 0);
         if1.sin_bs = 1'($urandom_range(0, 1));
         if1.cos_bs = 1'($urandom_range(0, 1));
         step();
      end

      // Small instance: sin pattern 1,1,1,0 (mean +0.5), cos held low (saturated negative).
      apply_reset();
      cur = 1; nstr = 0; last = 0;
      for (int i = 0; i < 48; i++) begin
         if1.en     = 1'b1;
         if1.sin_bs = ((i % 4) != 3);
         if1.cos_bs = 1'b0;
         step();
         cur++;
         if (if1.out_valid) begin
            if (nstr == 0) cmp("dut1_first_strobe_cycle", cur, 3 * R1 + 1);
            else           cmp("dut1_strobe_spacing", cur - last, R1);
            cmp("dut1_half_scale_sin", int'(if1.sin_out), 32);
            cmp("dut1_full_scale_cos", int'(if1.cos_out), -64);
            last = cur;
            nstr++;
         end
      end
      cmp("dut1_strobe_count", nstr, 10);
      idle_inputs();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1);
   end

endmodule
